mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
Multi-cycle control sequencer for the single-issue RISC-V core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB. It generates the per-stage load/write enables and the instruction/data memory request handshakes, and gates the decoder's static t_ctrl bundle into one-cycle-qualified strobes. It sits between the decoder/datapath and the memory ports, and owns trap detection and the retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for ack before trapping (>=2)
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; sampled only in IDLE
halt_req  in  1  stop after current instruction retires; sampled only in WB
opcode  in  7  instruction[6:0] from instruction register
ctrl  in  t_ctrl  decoder control bundle (reg_wr_en, mem_wr_en, mem_byt_en used)
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid this cycle
dmem_req  out  1  data memory request
dmem_we  out  1  data write qualifier (valid only with dmem_req)
dmem_ack  in  1  data access complete this cycle
ir_ld  out  1  load instruction register
alu_ld  out  1  latch ALU result register
mdr_ld  out  1  latch memory data register (loads only)
rf_wr_en  out  1  register-file write strobe
pc_ld  out  1  update PC with next-pc mux
busy  out  1  high in any state except IDLE and TRAP
trap  out  1  sticky trap flag
trap_cause  out  2  t_trap_cause: NONE/ILLEGAL/IMEM_TO/DMEM_TO
instret  out  INSTRET_W  retired instruction count

Behaviour:
- States (t_seq_state): IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs are Moore-decoded from state, except the ack-qualified strobes noted below.
- Reset (async, rst_n=0): state=IDLE, timeout counter=0, instret=0, trap=0, trap_cause=NONE. All strobes and reqs are 0. Reset mid-transaction drops requests immediately; no outstanding-access tracking.
- IDLE: all strobes 0. Goes to FETCH on the next edge when en=1.
- FETCH: imem_req=1. When imem_ack=1, ir_ld=1 in the same cycle and next state is DECODE. Otherwise the timeout counter increments. If the count reaches MEM_TIMEOUT-1 with no ack, next state is TRAP with cause IMEM_TO. Ack and the terminal count in the same cycle: ack wins.
- DECODE: one cycle. If opcode is not in the package SUPPORTED_OPCODES list, go to TRAP with cause ILLEGAL; otherwise go to EXEC.
- EXEC: alu_ld=1 for one cycle. Go to MEM if ctrl.mem_byt_en != 0, else go to WB.
- MEM: dmem_req=1 and dmem_we=ctrl.mem_wr_en, both held stable until ack. On dmem_ack, mdr_ld = !ctrl.mem_wr_en and next state is WB. Timeout follows the FETCH rules, with cause DMEM_TO.
- Timeout counter clears on every state entry. Its width is $clog2(MEM_TIMEOUT).
- WB: one cycle. rf_wr_en=ctrl.reg_wr_en, pc_ld=1, instret increments (wraps modulo 2^INSTRET_W). Next state is IDLE if halt_req=1, else FETCH. A fresh en is required to restart from IDLE.
- TRAP: terminal state. trap=1 and trap_cause are held, no strobes, en is ignored. Only rst_n exits TRAP.
- A trapping instruction never asserts rf_wr_en or pc_ld, and instret does not count it.
- Fixed latency with zero-wait memory (ack in the first request cycle): 4 cycles for non-memory instructions (FETCH, DECODE, EXEC, WB), 5 cycles for load/store.
- ctrl is only used from DECODE onward. It is stable there because the instruction register loads only in FETCH.

Decomposition:
- cpu_pkg additions: t_seq_state enum, t_trap_cause enum (2b), opcode constants (OP_R=7'b0110011, OP_I=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011), and SUPPORTED_OPCODES.
- Sub-module mem_wait_timer: counter with clear, inc and terminal-count output. It is shared by FETCH and MEM.
- State register uses the dff_macros async-reset flop macro.

Test Plan:
- ADDI, imem_ack in first cycle, en=1 → imem_req, ir_ld, alu_ld, rf_wr_en+pc_ld on cycles 1-4; instret 0→1; next instruction fetch starts at cycle 5.
- Store (opcode 0100011, mem_byt_en=4'b1111, mem_wr_en=1), dmem_ack after 3 cycles → dmem_req and dmem_we held 3 cycles, mdr_ld never asserts, rf_wr_en=ctrl.reg_wr_en in WB.
- Opcode 7'b1111111 → TRAP after DECODE; trap=1, trap_cause=ILLEGAL, no rf_wr_en/pc_ld, instret unchanged; en toggling has no effect.
- imem_ack never asserted, MEM_TIMEOUT=16 → imem_req high exactly 16 cycles, then TRAP with cause IMEM_TO. Ack on the 16th cycle instead → DECODE, no trap.
- rst_n pulsed low during MEM wait → dmem_req drops asynchronously, state IDLE, instret=0; restart with en completes normally.
- halt_req high during WB of instruction N → IDLE, busy=0, no further imem_req; instret=N. INSTRET_W=4 run of 17 instructions → instret wraps to 1.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
// Shared types and opcode constants for the multi-cycle control sequencer.
package mc_sequencer_pkg;

  typedef struct packed {
    logic       reg_wr_en;
    logic       mem_wr_en;
    logic [3:0] mem_byt_en;
  } t_ctrl;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } t_seq_state;

  typedef enum logic [1:0] {
    NONE,
    ILLEGAL,
    IMEM_TO,
    DMEM_TO
  } t_trap_cause;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int N_SUPPORTED = 4;
  localparam logic [6:0] SUPPORTED_OPCODES [N_SUPPORTED] = '{OP_R, OP_I, OP_LOAD, OP_STORE};

  function automatic logic is_supported(input logic [6:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_SUPPORTED; i++) begin
      if (op == SUPPORTED_OPCODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/mc_sequencer_mem_wait_timer.sv
// Wait-cycle counter shared by instruction fetch and data access; tc flags the
// last cycle a request may stay unacknowledged.
module mc_sequencer_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: stage strobes, memory
// handshakes, trap detection and retired-instruction count.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 halt_req,
  input  logic [6:0]           opcode,
  input  t_ctrl                ctrl,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 ir_ld,
  output logic                 alu_ld,
  output logic                 mdr_ld,
  output logic                 rf_wr_en,
  output logic                 pc_ld,
  output logic                 busy,
  output logic                 trap,
  output t_trap_cause          trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  t_seq_state            state_q, state_d;
  t_trap_cause           cause_q, cause_d;
  logic [INSTRET_W-1:0]  instret_q, instret_d;
  logic                  tmr_clr, tmr_inc, tmr_tc;

  mc_sequencer_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .tc    (tmr_tc)
  );

  // Handshake: a request stays high and stable until the cycle its ack is
  // seen; the ack-qualified strobes (ir_ld, mdr_ld) fire in that same cycle.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    tmr_inc   = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_ld     = 1'b0;
    alu_ld    = 1'b0;
    mdr_ld    = 1'b0;
    rf_wr_en  = 1'b0;
    pc_ld     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_ld   = 1'b1;
          state_d = DECODE;
        end else if (tmr_tc) begin
          state_d = TRAP;
          cause_d = IMEM_TO;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      DECODE: begin
        if (!is_supported(opcode)) begin
          state_d = TRAP;
          cause_d = ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_ld  = 1'b1;
        state_d = (|ctrl.mem_byt_en) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl.mem_wr_en;
        if (dmem_ack) begin
          mdr_ld  = !ctrl.mem_wr_en;
          state_d = WB;
        end else if (tmr_tc) begin
          state_d = TRAP;
          cause_d = DMEM_TO;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      WB: begin
        rf_wr_en  = ctrl.reg_wr_en;
        pc_ld     = 1'b1;
        instret_d = instret_q + INSTRET_W'(1);
        state_d   = halt_req ? IDLE : FETCH;
      end
      TRAP: begin
      end
      default: state_d = IDLE;
    endcase
  end

  // Every state change restarts the wait count for the next request.
  assign tmr_clr = (state_d != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cause_q   <= NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign busy       = (state_q != IDLE) && (state_q != TRAP);
  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed latency table, trap/reset sequences and a
// randomized instruction stream checked cycle-by-cycle against a trace model.
module tb_mc_sequencer;
  import mc_sequencer_pkg::*;

  localparam int TO = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, halt_req, imem_ack, dmem_ack;
  logic [6:0]    opcode;
  t_ctrl         ctrl;
  logic          imem_req, dmem_req, dmem_we, ir_ld, alu_ld, mdr_ld;
  logic          rf_wr_en, pc_ld, busy, trap;
  t_trap_cause   trap_cause;
  logic [IW-1:0] instret;

  int n_checks = 0;
  int n_err    = 0;

  mc_sequencer #(.MEM_TIMEOUT(TO), .INSTRET_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .halt_req   (halt_req),
    .opcode     (opcode),
    .ctrl       (ctrl),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .ir_ld      (ir_ld),
    .alu_ld     (alu_ld),
    .mdr_ld     (mdr_ld),
    .rf_wr_en   (rf_wr_en),
    .pc_ld      (pc_ld),
    .busy       (busy),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  localparam logic [9:0] F_IREQ = 10'b1000000000;
  localparam logic [9:0] F_IRLD = 10'b0100000000;
  localparam logic [9:0] F_ALU  = 10'b0010000000;
  localparam logic [9:0] F_DREQ = 10'b0001000000;
  localparam logic [9:0] F_DWE  = 10'b0000100000;
  localparam logic [9:0] F_MDR  = 10'b0000010000;
  localparam logic [9:0] F_RF   = 10'b0000001000;
  localparam logic [9:0] F_PC   = 10'b0000000100;
  localparam logic [9:0] F_BUSY = 10'b0000000010;

  typedef struct packed {
    logic       en;
    logic       halt;
    logic       iack;
    logic       dack;
    logic [6:0] op;
    logic       rw;
    logic       mw;
    logic [3:0] be;
  } stim_t;

  stim_t       stim_q[$];
  logic [15:0] exp_q[$];
  int          model_n;

  function automatic logic [15:0] act();
    return {imem_req, ir_ld, alu_ld, dmem_req, dmem_we, mdr_ld, rf_wr_en, pc_ld,
            busy, trap, trap_cause, instret};
  endfunction

  function automatic logic [15:0] ev(input logic [9:0] f, input int n);
    return {f, 2'b00, 4'(n)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic stim_t jit(input stim_t s);
    stim_t r;
    r      = s;
    r.en   = 1'($urandom_range(0, 1));
    r.halt = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Trace model: one instruction expands into its per-cycle stimulus and the
  // outputs the stage rules demand, assuming no timeout.
  function automatic void plan_instr(input logic [6:0] op, input logic rw, input logic mw,
                                     input logic [3:0] be, input int fd, input int md,
                                     input logic halt, input logic restart);
    stim_t       s;
    logic [9:0]  mf;
    s  = '{en: 1'b0, halt: 1'b0, iack: 1'b0, dack: 1'b0, op: op, rw: rw, mw: mw, be: be};
    mf = F_DREQ | (mw ? F_DWE : 10'd0) | F_BUSY;
    for (int k = 0; k < fd; k++) begin
      stim_q.push_back(jit(s)); exp_q.push_back(ev(F_IREQ | F_BUSY, model_n));
    end
    s.iack = 1'b1;
    stim_q.push_back(jit(s)); exp_q.push_back(ev(F_IREQ | F_IRLD | F_BUSY, model_n));
    s.iack = 1'($urandom_range(0, 1)); s.dack = 1'($urandom_range(0, 1));
    stim_q.push_back(jit(s)); exp_q.push_back(ev(F_BUSY, model_n));
    stim_q.push_back(jit(s)); exp_q.push_back(ev(F_ALU | F_BUSY, model_n));
    s.iack = 1'b0; s.dack = 1'b0;
    if (be != 4'd0) begin
      for (int k = 0; k < md; k++) begin
        stim_q.push_back(jit(s)); exp_q.push_back(ev(mf, model_n));
      end
      s.dack = 1'b1;
      stim_q.push_back(jit(s)); exp_q.push_back(ev(mf | (mw ? 10'd0 : F_MDR), model_n));
      s.dack = 1'b0;
    end
    s      = jit(s);
    s.halt = halt;
    stim_q.push_back(s); exp_q.push_back(ev(F_PC | (rw ? F_RF : 10'd0) | F_BUSY, model_n));
    model_n = (model_n + 1) % 16;
    if (halt) begin
      s.halt = 1'b0; s.en = 1'b0;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        stim_q.push_back(s); exp_q.push_back(ev(10'd0, model_n));
      end
      if (restart) begin
        s.en = 1'b1;
        stim_q.push_back(s); exp_q.push_back(ev(10'd0, model_n));
      end
    end
  endfunction

  task automatic apply(input stim_t s);
    en = s.en; halt_req = s.halt; imem_ack = s.iack; dmem_ack = s.dack;
    opcode = s.op;
    ctrl.reg_wr_en = s.rw; ctrl.mem_wr_en = s.mw; ctrl.mem_byt_en = s.be;
  endtask

  task automatic run_plan();
    int          idx = 0;
    stim_t       s;
    logic [15:0] e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      apply(s);
      #1;
      check($sformatf("plan_cycle_%0d", idx), 32'(act()), 32'(e));
      idx++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic        rw;
    logic        mw;
    logic [3:0]  be;
    int          fd;
    int          md;
    int          lat;
    int          nir;
    int          ndr;
    t_trap_cause cause;
    int          instret;
  } rec_t;

  rec_t tbl[9];

  // Acks are returned after fd (fetch) / md (data) unacknowledged cycles.
  task automatic run_reactive(input rec_t r, input bit do_rst, input string tag);
    int lat = 0, fw = 0, mc = 0, nrf = 0, nmdr = 0;
    if (do_rst) do_reset();
    @(negedge clk);
    opcode = r.op;
    ctrl.reg_wr_en = r.rw; ctrl.mem_wr_en = r.mw; ctrl.mem_byt_en = r.be;
    en = 1'b1; halt_req = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      en       = 1'b0;
      imem_ack = imem_req && (fw == r.fd);
      dmem_ack = dmem_req && (mc == r.md);
      #1;
      if (imem_req) fw++;
      if (dmem_req) mc++;
      if (rf_wr_en) nrf++;
      if (mdr_ld)   nmdr++;
      if (pc_ld || trap) begin
        lat = cyc;
        break;
      end
    end
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
    #1;
    check({tag, "_latency"}, 32'(lat), 32'(r.lat));
    check({tag, "_imem_req_cycles"}, 32'(fw), 32'(r.nir));
    check({tag, "_dmem_req_cycles"}, 32'(mc), 32'(r.ndr));
    check({tag, "_rf_wr_en_cycles"}, 32'(nrf), (r.cause == NONE && r.rw) ? 32'd1 : 32'd0);
    check({tag, "_mdr_ld_cycles"}, 32'(nmdr),
          (r.cause == NONE && r.be != 4'd0 && !r.mw) ? 32'd1 : 32'd0);
    check({tag, "_trap_cause"}, 32'(trap_cause), 32'(r.cause));
    check({tag, "_instret"}, 32'(instret), 32'(r.instret));
  endtask

  // ---------------- test ----------------
  initial begin
    int   got_mem;
    rst_n = 1'b0; en = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    opcode = 7'd0; ctrl = '0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", 32'(act()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //            op        rw    mw    be     fd  md  lat nir ndr cause    instret
    tbl[0] = '{OP_I,     1'b1, 1'b0, 4'h0,  0,  0,  4,  1,  0, NONE,    1};
    tbl[1] = '{OP_STORE, 1'b0, 1'b1, 4'hF,  0,  2,  7,  1,  3, NONE,    1};
    tbl[2] = '{OP_LOAD,  1'b1, 1'b0, 4'hF,  2,  0,  7,  3,  1, NONE,    1};
    tbl[3] = '{7'h7F,    1'b1, 1'b0, 4'h0,  0,  0,  3,  1,  0, ILLEGAL, 0};
    tbl[4] = '{OP_I,     1'b1, 1'b0, 4'h0, 16,  0, 17, 16,  0, IMEM_TO, 0};
    tbl[5] = '{OP_I,     1'b1, 1'b0, 4'h0, 15,  0, 19, 16,  0, NONE,    1};
    tbl[6] = '{OP_LOAD,  1'b1, 1'b0, 4'h1,  0, 16, 20,  1, 16, DMEM_TO, 0};
    tbl[7] = '{OP_STORE, 1'b1, 1'b1, 4'h3,  0, 15, 20,  1, 16, NONE,    1};
    tbl[8] = '{OP_R,     1'b1, 1'b0, 4'h0,  1,  0,  5,  2,  0, NONE,    1};
    for (int i = 0; i < 9; i++) run_reactive(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Trap is terminal: en and acks have no effect.
    run_reactive(tbl[3], 1'b1, "trap_hold");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1)); imem_ack = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("trap_hold_%0d", i), {27'd0, trap, busy, imem_req, trap_cause, instret},
            {27'd0, 1'b1, 1'b0, 1'b0, ILLEGAL, 4'd0});
    end
    en = 1'b0; imem_ack = 1'b0;

    // Randomized stream against the trace model; 40 retirements wrap a 4-bit count.
    do_reset();
    model_n = 0;
    stim_q.push_back('{en: 1'b1, halt: 1'b0, iack: 1'b0, dack: 1'b0, op: 7'd0,
                       rw: 1'b0, mw: 1'b0, be: 4'd0});
    exp_q.push_back(ev(10'd0, 0));
    for (int i = 0; i < 40; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 3))
        0:       op = OP_R;
        1:       op = OP_I;
        2:       op = OP_LOAD;
        default: op = OP_STORE;
      endcase
      plan_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                 ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3)),
                 (i == 39) || ($urandom_range(0, 5) == 0), i != 39);
    end
    run_plan();
    #1 check("instret_after_40", 32'(instret), 32'd8);

    // Reset while waiting on a data ack drops the request at once.
    @(negedge clk);
    opcode = OP_STORE; ctrl = '{reg_wr_en: 1'b0, mem_wr_en: 1'b1, mem_byt_en: 4'hF};
    en = 1'b1; halt_req = 1'b0;
    got_mem = 0;
    for (int c = 0; c < 20 && got_mem == 0; c++) begin
      @(negedge clk);
      en = 1'b0; imem_ack = imem_req; dmem_ack = 1'b0;
      #1;
      if (dmem_req) got_mem = 1;
    end
    imem_ack = 1'b0;
    check("reach_mem", 32'(got_mem), 32'd1);
    check("mem_wait_we", {30'd0, dmem_we, busy}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_mem", 32'(act()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_reactive(tbl[0], 1'b0, "restart");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
